// File: rtl/reg_load_pkg.sv
// Shared types and helpers for the load-register round-robin scheduler.
package reg_load_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK
    } sched_state_e;

    localparam int unsigned ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan by distance from ptr so every select uses a loop constant index.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!any && req[i] &&
                    ((i + int'(NREQ) - int'(ptr)) % int'(NREQ)) == k) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/reg_load_sched.sv
// Round-robin scheduler sharing one load register among NREQ requesters,
// with readback verification and a saturating mismatch counter.
module reg_load_sched
    import reg_load_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter bit          VERIFY_EN = 1'b1,
    localparam int unsigned IW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 load_en,
    output logic [DW-1:0]        d,
    input  logic [DW-1:0]        q,
    output logic                 rsp_valid,
    output logic [IW-1:0]        rsp_id,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    sched_state_e         state_q, state_d;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        id_q;
    logic [DW-1:0]        data_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [NREQ-1:0]      pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [DW-1:0]        sel_data;
    logic                 accept;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_gnt[i]) begin
                sel_data = req_data[i*int'(DW) +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        load_en   = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready = pick_gnt;
                    accept    = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                rsp_valid = 1'b1;
                // Case inequality so an X readback counts as a mismatch.
                rsp_err   = VERIFY_EN && (q !== data_q);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            data_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= sel_data;
                id_q   <= pick_idx;
                ptr_q  <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (rsp_err) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    assign d       = data_q;
    assign rsp_id  = id_q;
    assign busy    = (state_q != IDLE);
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_reg_load_sched.sv
// Directed self-checking bench for reg_load_sched with a simple register model.
module tb_reg_load_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        load_en;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  err_cnt;

    logic [3:0]  req_ready1;
    logic        load_en1;
    logic [7:0]  d1;
    logic        rsp_valid1;
    logic [1:0]  rsp_id1;
    logic        rsp_err1;
    logic        busy1;
    logic [7:0]  err_cnt1;

    logic [7:0]  reg_q = 8'h00;
    logic        corrupt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) reg_q <= d;
    end
    assign q = corrupt ? 8'h00 : reg_q;

    reg_load_sched #(.NREQ(4), .DW(8), .VERIFY_EN(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .load_en   (load_en),
        .d         (d),
        .q         (q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    reg_load_sched #(.NREQ(4), .DW(8), .VERIFY_EN(1'b0)) dut_nv (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready1),
        .load_en   (load_en1),
        .d         (d1),
        .q         (q),
        .rsp_valid (rsp_valid1),
        .rsp_id    (rsp_id1),
        .rsp_err   (rsp_err1),
        .busy      (busy1),
        .err_cnt   (err_cnt1)
    );

    task automatic test_reset;
        #1;
        checks++;
        if ({req_ready, load_en, d, rsp_valid, rsp_id, rsp_err, busy, err_cnt} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {req_ready, load_en, d, rsp_valid, rsp_id, rsp_err, busy, err_cnt});
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({busy, load_en, rsp_valid, req_ready} !== 7'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0", {busy, load_en, rsp_valid, req_ready});
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (load_en !== 1'b1 || d !== 8'hA5) begin
            errors++; $display("FAIL single_load: got en=%b d=%h want en=1 d=a5", load_en, d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%0d err=%b want v=1 id=2 err=0",
                     rsp_valid, rsp_id, rsp_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || load_en !== 1'b0 || busy !== 1'b0 || d !== 8'hA5) begin
            errors++;
            $display("FAIL single_idle: got v=%b en=%b busy=%b d=%h want 0 0 0 a5",
                     rsp_valid, load_en, busy, d);
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        req_data[15:8] = 8'h11;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL wrap_ready: got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            errors++; $display("FAIL wrap_rsp: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id);
        end
        @(negedge clk);
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL wrap_ptr_next: got %b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_mid_load_reset;
        @(negedge clk);
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_ready: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (load_en !== 1'b1) begin
            errors++; $display("FAIL midrst_load: got %b want 1", load_en);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, load_en, d, rsp_valid, rsp_id, rsp_err, busy, err_cnt} !== 26'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 0",
                     {req_ready, load_en, d, rsp_valid, rsp_id, rsp_err, busy, err_cnt});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_rsp: got v=%b busy=%b want 0 0", rsp_valid, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ready;
        logic [1:0] exp_id;
        logic [7:0] exp_d;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        for (int k = 0; k < 15; k++) begin
            if (k == 13) req_valid = 4'b0000;
            #1;
            exp_id    = 2'((k / 3) % 4);
            exp_d     = 8'h11 * (8'(exp_id) + 8'd1);
            exp_ready = (k % 3 == 0) ? (4'b0001 << exp_id) : 4'b0000;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_ready);
            end
            if (k % 3 == 1) begin
                checks++;
                if (load_en !== 1'b1 || d !== exp_d) begin
                    errors++;
                    $display("FAIL rr_load[%0d]: got en=%b d=%h want en=1 d=%h",
                             k, load_en, d, exp_d);
                end
            end
            if (k % 3 == 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d]: got v=%b id=%0d err=%b want v=1 id=%0d err=0",
                             k, rsp_valid, rsp_id, rsp_err, exp_id);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mismatch;
        corrupt = 1'b1;
        @(negedge clk);
        req_data[15:8] = 8'h3C;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL mm_ready: got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (d !== 8'h3C || d1 !== 8'h3C) begin
            errors++; $display("FAIL mm_d: got %h/%h want 3c/3c", d, d1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            errors++; $display("FAIL mm_err: got v=%b err=%b want 1 1", rsp_valid, rsp_err);
        end
        checks++;
        if (rsp_valid1 !== 1'b1 || rsp_err1 !== 1'b0) begin
            errors++; $display("FAIL mm_noverify: got v=%b err=%b want 1 0", rsp_valid1, rsp_err1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (err_cnt !== 8'd1 || err_cnt1 !== 8'd0) begin
            errors++; $display("FAIL mm_cnt: got %0d/%0d want 1/0", err_cnt, err_cnt1);
        end
    endtask

    task automatic do_write(input int idx, input logic [7:0] data);
        bit got;
        @(negedge clk);
        req_data[idx*8 +: 8] = data;
        req_valid = 4'b0001 << idx;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            #1;
            if (req_ready[idx]) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL write_handshake: got no ready want ready[%0d]", idx);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_saturate;
        for (int n = 0; n < 253; n++) do_write(2, 8'h3C);
        #1;
        checks++;
        if (err_cnt !== 8'hFE) begin
            errors++; $display("FAIL sat_254: got %h want fe", err_cnt);
        end
        for (int n = 0; n < 46; n++) do_write(3, 8'h3C);
        #1;
        checks++;
        if (err_cnt !== 8'hFF) begin
            errors++; $display("FAIL sat_300: got %h want ff", err_cnt);
        end
        checks++;
        if (err_cnt1 !== 8'h00) begin
            errors++; $display("FAIL sat_noverify: got %h want 00", err_cnt1);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        corrupt   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_wrap();
        test_mid_load_reset();
        test_round_robin();
        test_mismatch();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
